// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the riscv_uc control unit.
//   State codes (3-bit), opcode constants, alu_op codes, mux select codes
//   and the decoded instruction class type.
package riscv_pkg;
   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SEL_RS2 = 2'd0;
   localparam logic [1:0] SEL_IMM = 2'd1;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] ST_ALU  = 2'd0;
   localparam logic [1:0] ST_RS2  = 2'd1;
   typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILL} cls_e;
endpackage

// File: rtl/riscv_uc_if.sv
// riscv_uc_if: control bus between riscv_uc (master) and the riscv_dp datapath (slave).
//   opcode/branch flow datapath -> control; strobes and mux selects flow control -> datapath.
interface riscv_uc_if;
   logic [6:0] opcode;
   logic       branch;
   logic       pc_load;
   logic       pc_reset;
   logic       mem_re;
   logic       mem_we;
   logic       reg_file_write;
   logic [1:0] alu_op;
   logic [1:0] select_mux_1;
   logic [1:0] select_mux_2;
   logic [1:0] select_mux_3;
   logic [1:0] select_mux_4;
   modport master (
      input  opcode, branch,
      output pc_load, pc_reset, mem_re, mem_we, reg_file_write,
             alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4
   );
   modport slave (
      output opcode, branch,
      input  pc_load, pc_reset, mem_re, mem_we, reg_file_write,
             alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4
   );
endinterface

// File: rtl/riscv_uc_decode.sv
// riscv_uc_decode: combinational opcode-to-class decode.
//   i_opcode: instruction [6:0]; o_cls: instruction class (CLS_ILL for unknown opcodes).
module riscv_uc_decode
   import riscv_pkg::*;
(
   input  logic [6:0] i_opcode,
   output cls_e       o_cls
);
   always_comb
      o_cls = i_opcode == OP_R      ? CLS_R      :
              i_opcode == OP_I      ? CLS_I      :
              i_opcode == OP_LOAD   ? CLS_LOAD   :
              i_opcode == OP_STORE  ? CLS_STORE  :
              i_opcode == OP_BRANCH ? CLS_BRANCH : CLS_ILL;
endmodule

// File: rtl/riscv_uc.sv
// riscv_uc: multicycle control unit sequencing each instruction for riscv_dp.
//   clk, reset (async, active-low); ctl: control bus (master side);
//   halted: high in HALT; instret: retired-instruction count (wraps).
module riscv_uc
   import riscv_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   riscv_uc_if.master       ctl,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);
   logic [2:0]       r_state;
   logic [2:0]       w_next;
   cls_e             r_cls;
   cls_e             w_cls;
   logic [CNT_W-1:0] r_instret;
   logic             w_ex, w_mem, w_wb, w_ld, w_st, w_ri, w_br;

   riscv_uc_decode u_dec (.i_opcode(ctl.opcode), .o_cls(w_cls));

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= S_RESET;
      else        r_state <= w_next;

   // every pc_load retires an instruction, so it doubles as the count enable
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_cls     <= CLS_ILL;
         r_instret <= '0;
      end else begin
         if (r_state == S_DECODE) r_cls <= w_cls;
         if (ctl.pc_load) r_instret <= r_instret + CNT_W'(1);
      end

   // DECODE steers on the live decode since r_cls is only loaded on its exit edge;
   // a non-halting illegal still passes through an idle EXEC so a NOP costs 4 cycles
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RESET:  w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = (w_cls == CLS_ILL && HALT_ON_ILLEGAL) ? S_HALT : S_EXEC;
         S_EXEC:   w_next = w_br ? S_FETCH : (w_ld || w_st) ? S_MEM : S_WB;
         S_MEM:    w_next = w_ld ? S_WB : S_FETCH;
         S_WB:     w_next = S_FETCH;
         default:  w_next = S_HALT;
      endcase
   end

   assign w_ex  = r_state == S_EXEC;
   assign w_mem = r_state == S_MEM;
   assign w_wb  = r_state == S_WB;
   assign w_ld  = r_cls == CLS_LOAD;
   assign w_st  = r_cls == CLS_STORE;
   assign w_ri  = r_cls == CLS_R || r_cls == CLS_I;
   assign w_br  = r_cls == CLS_BRANCH;

   // MEM repeats EXEC's ALU controls so the address stays stable for the access
   always_comb begin
      ctl.pc_reset       = r_state == S_RESET;
      ctl.alu_op         = !(w_ex || w_mem) ? ALU_ADD : w_ri ? ALU_FUNCT : w_br ? ALU_SUB : ALU_ADD;
      ctl.select_mux_1   = (w_ex || w_mem) && (r_cls == CLS_I || w_ld || w_st) ? SEL_IMM : SEL_RS2;
      ctl.mem_re         = w_ld && (w_mem || w_wb);
      ctl.mem_we         = w_st && w_mem;
      ctl.select_mux_4   = w_st && w_mem ? ST_RS2 : ST_ALU;
      ctl.reg_file_write = w_wb && (w_ri || w_ld);
      ctl.select_mux_2   = w_wb && w_ld ? WB_MEM : WB_ALU;
      ctl.pc_load        = w_wb || (w_ex && w_br) || (w_mem && w_st);
      ctl.select_mux_3   = w_ex && w_br ? {1'b0, ctl.branch} : PC_INC;
      halted             = r_state == S_HALT;
   end

   assign instret = r_instret;
endmodule

// File: tb/tb_riscv_uc.sv
// tb_riscv_uc: self-checking bench for riscv_uc; one instance halts on illegal opcodes,
//   the other retires them as NOPs and uses a 2-bit counter to exercise wrap-around.
module tb_riscv_uc;
   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  op_s  = '0;
   logic        br_s  = 1'b0;
   logic        halted_h, halted_n;
   logic [31:0] instret_h;
   logic [1:0]  instret_n;
   logic [15:0] v_h, v_n;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cnt_h = 0;
   int          cnt_n = 0;

   // output vector layout: pcl pcr re we rfw alu[2] m1[2] m2[2] m3[2] m4[2] halted
   localparam logic [15:0] V_RST  = 16'h4000;
   localparam logic [15:0] V_HALT = 16'h0001;

   riscv_uc_if ifh();
   riscv_uc_if ifn();
   assign ifh.opcode = op_s;
   assign ifh.branch = br_s;
   assign ifn.opcode = op_s;
   assign ifn.branch = br_s;

   riscv_uc #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut_h (
      .clk(clk), .reset(reset), .ctl(ifh), .halted(halted_h), .instret(instret_h));
   riscv_uc #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(2)) dut_n (
      .clk(clk), .reset(reset), .ctl(ifn), .halted(halted_n), .instret(instret_n));

   assign v_h = {ifh.pc_load, ifh.pc_reset, ifh.mem_re, ifh.mem_we, ifh.reg_file_write, ifh.alu_op,
                 ifh.select_mux_1, ifh.select_mux_2, ifh.select_mux_3, ifh.select_mux_4, halted_h};
   assign v_n = {ifn.pc_load, ifn.pc_reset, ifn.mem_re, ifn.mem_we, ifn.reg_file_write, ifn.alu_op,
                 ifn.select_mux_1, ifn.select_mux_2, ifn.select_mux_3, ifn.select_mux_4, halted_n};

   always #5 clk = ~clk;

   // classes: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal
   function automatic logic [6:0] opc(int c);
      return c == 0 ? 7'b0110011 : c == 1 ? 7'b0010011 : c == 2 ? 7'b0000011 :
             c == 3 ? 7'b0100011 : c == 4 ? 7'b1100011 : 7'b1111111;
   endfunction

   function automatic int lat(int c);
      return c == 4 ? 3 : c == 2 ? 5 : 4;
   endfunction

   // expected outputs in cycle k (0 = FETCH) of a class-c instruction lasting len cycles
   function automatic logic [15:0] expv(int c, int k, int len, logic br);
      logic last, ex, mm, wb;
      logic [1:0] alu;
      last = k == len - 1;
      ex   = k == 2;
      mm   = k == 3 && (c == 2 || c == 3);
      wb   = last && (c == 0 || c == 1 || c == 2 || c == 5);
      alu  = !(ex || mm) ? 2'b00 : c <= 1 ? 2'b10 : c == 4 ? 2'b01 : 2'b00;
      return {last, 1'b0, c == 2 && k >= 3, c == 3 && k == 3, wb && c != 5, alu,
              {1'b0, (ex || mm) && c >= 1 && c <= 3}, {1'b0, wb && c == 2},
              {1'b0, ex && c == 4 && br}, {1'b0, c == 3 && k == 3}, 1'b0};
   endfunction

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic cycle_in(logic [6:0] op, logic br);
      @(negedge clk);
      op_s = op;
      br_s = br;
      #1;
   endtask

   task automatic chk_cnt(string tag);
      chk({tag, "_instret_h"}, instret_h, 32'(cnt_h));
      chk({tag, "_instret_n"}, {30'b0, instret_n}, 32'(cnt_n));
   endtask

   task automatic chk_rst(string tag);
      chk({tag, "_h"}, {16'b0, v_h}, {16'b0, V_RST});
      chk({tag, "_n"}, {16'b0, v_n}, {16'b0, V_RST});
      chk_cnt(tag);
   endtask

   // runs one instruction on both DUTs; opcode is garbage outside DECODE, and
   // abort_k >= 0 pulls reset shortly after that cycle has been checked
   task automatic run_instr(int c, int bmode, int abort_k);
      int len;
      logic br;
      len = lat(c);
      for (int k = 0; k < len; k++) begin
         br = bmode < 0 ? 1'($urandom) : bmode[0];
         cycle_in(k == 1 ? opc(c) : 7'($urandom), br);
         chk_cnt($sformatf("c%0d_k%0d", c, k));
         chk($sformatf("out_h_c%0d_k%0d", c, k), {16'b0, v_h}, {16'b0, expv(c, k, len, br)});
         chk($sformatf("out_n_c%0d_k%0d", c, k), {16'b0, v_n}, {16'b0, expv(c, k, len, br)});
         if (k == abort_k) begin
            #2 reset = 1'b0;
            #1;
            cnt_h = 0;
            cnt_n = 0;
            chk_rst("abort");
            return;
         end
      end
      cnt_h++;
      cnt_n = (cnt_n + 1) % 4;
   endtask

   task automatic release_reset(string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_rst(tag);
   endtask

   initial begin
      repeat (3) begin
         @(negedge clk);
         #1;
         chk_rst("in_reset");
      end
      release_reset("rst_release");
      run_instr(0, -1, -1);
      run_instr(2, -1, -1);
      run_instr(3, -1, -1);
      run_instr(4, 1, -1);
      run_instr(4, 0, -1);
      repeat (40) run_instr(int'($urandom_range(0, 4)), -1, -1);
      for (int k = 0; k < 4; k++) begin
         logic br;
         br = 1'($urandom);
         cycle_in(k == 1 ? opc(5) : 7'($urandom), br);
         chk_cnt($sformatf("ill_k%0d", k));
         chk($sformatf("ill_n_k%0d", k), {16'b0, v_n}, {16'b0, expv(5, k, 4, br)});
         chk($sformatf("ill_h_k%0d", k), {16'b0, v_h}, k < 2 ? 32'h0 : {16'b0, V_HALT});
      end
      cnt_n = (cnt_n + 1) % 4;
      repeat (8) begin
         cycle_in(7'($urandom), 1'($urandom));
         chk("halt_h", {16'b0, v_h}, {16'b0, V_HALT});
         chk("halt_instret_h", instret_h, 32'(cnt_h));
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      cnt_h = 0;
      cnt_n = 0;
      chk_rst("halt_exit");
      release_reset("halt_release");
      repeat (10) run_instr(int'($urandom_range(0, 4)), -1, -1);
      run_instr(2, -1, 3);
      @(negedge clk);
      #1;
      chk_rst("abort_hold");
      release_reset("abort_release");
      repeat (10) run_instr(int'($urandom_range(0, 4)), -1, -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
